slink_rx_mux: RTL

SLINK_RX_MUX -- requirements
Module: slink_rx_mux

---
 rtl/slink_rx_mux_if.sv | 28 ++
 rtl/slink_rx_mux.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/slink_rx_mux_if.sv
// Bundles the per-channel MAC receive strobes and the downstream word read port.
interface slink_rx_mux_if #(
  parameter int unsigned CH_NUM = 2
);
  logic [CH_NUM-1:0]   rx_dval;
  logic [CH_NUM-1:0]   rx_sop;
  logic [CH_NUM-1:0]   rx_eop;
  logic [CH_NUM-1:0]   rx_err;
  logic [8*CH_NUM-1:0] rx_data;
  logic                mm_rdreq;
  logic                mm_empty;
  logic                mm_dval;
  logic [17:0]         mm_data;
  logic [1:0]          mm_ch;
  logic [CH_NUM-1:0]   pkt_drop;

  // Traffic source: MAC receivers plus the downstream reader.
  modport master (
    output rx_dval, rx_sop, rx_eop, rx_err, rx_data, mm_rdreq,
    input  mm_empty, mm_dval, mm_data, mm_ch, pkt_drop
  );

  // The mux itself.
  modport slave (
    input  rx_dval, rx_sop, rx_eop, rx_err, rx_data, mm_rdreq,
    output mm_empty, mm_dval, mm_data, mm_ch, pkt_drop
  );
endinterface

// File: rtl/slink_rx_mux.sv
// Multi-channel byte receiver: packs bytes into 18-bit words per channel, buffers whole
// packets with commit/rollback, and forwards committed packets round-robin to one reader.
module slink_rx_mux #(
  parameter int unsigned CH_NUM  = 2,
  parameter int unsigned FIFO_AW = 6
) (
  input logic           clk_125m,
  input logic           rst_125m,
  slink_rx_mux_if.slave bus
);
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {StIdle, StArb, StXfer} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cur_q, cur_d, last_q, last_d, sel_ch, cand;
  logic        found, fire;
  logic [3:0]  pend;
  logic [17:0] rd_word [4];
  logic        dval_q;
  logic [17:0] data_q;
  logic [1:0]  ch_q;

  assign bus.mm_empty = (state_q != StXfer);
  assign fire         = bus.mm_rdreq && (state_q == StXfer);
  assign bus.mm_dval  = dval_q;
  assign bus.mm_data  = data_q;
  assign bus.mm_ch    = ch_q;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    if (k < CH_NUM) begin : g_on
      logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, base;
      logic          in_pkt_q, in_pkt_d, half_q, half_d, sop_q, sop_d;
      logic [7:0]    hi_q, hi_d, byte_in;
      logic          dval, sop, eop, err, full, want, wr_en, drop, drop_q, rd_inc;
      logic [17:0]   word;
      logic [17:0]   mem [DEPTH];

      assign dval    = bus.rx_dval[k];
      assign sop     = bus.rx_sop[k];
      assign eop     = bus.rx_eop[k];
      assign err     = bus.rx_err[k];
      assign byte_in = bus.rx_data[8*k +: 8];
      assign rd_inc  = fire && (cur_q == 2'(k));

      // Packer and write-side pointer update; a new packet always starts at the commit point.
      always_comb begin
        in_pkt_d = in_pkt_q;
        half_d   = half_q;
        sop_d    = sop_q;
        hi_d     = hi_q;
        wr_d     = wr_q;
        cm_d     = cm_q;
        want     = 1'b0;
        wr_en    = 1'b0;
        drop     = 1'b0;
        word     = '0;
        base     = (dval && sop && !err) ? cm_q : wr_q;
        full     = ((base - rd_q) == PW'(DEPTH));
        if (err) begin
          if (in_pkt_q) begin
            drop = 1'b1;
            wr_d = cm_q;
          end
          in_pkt_d = 1'b0;
          half_d   = 1'b0;
        end else if (dval && sop) begin
          if (in_pkt_q) begin
            drop = 1'b1;
            wr_d = cm_q;
          end
          in_pkt_d = 1'b1;
          half_d   = 1'b1;
          sop_d    = 1'b1;
          hi_d     = byte_in;
          if (eop) begin
            want = 1'b1;
            word = {2'b11, byte_in, 8'h00};
          end
        end else if (dval && in_pkt_q) begin
          if (half_q) begin
            want = 1'b1;
            word = {sop_q, eop, hi_q, byte_in};
          end else if (eop) begin
            want = 1'b1;
            word = {sop_q, 1'b1, byte_in, 8'h00};
          end else begin
            hi_d   = byte_in;
            half_d = 1'b1;
          end
        end
        if (want) begin
          half_d = 1'b0;
          if (full) begin
            drop     = 1'b1;
            wr_d     = cm_q;
            in_pkt_d = 1'b0;
          end else begin
            wr_en = 1'b1;
            wr_d  = base + PW'(1);
            sop_d = 1'b0;
            if (word[16]) begin
              cm_d     = base + PW'(1);
              in_pkt_d = 1'b0;
            end else begin
              in_pkt_d = 1'b1;
            end
          end
        end
      end

      // Channel state and pointers.
      always_ff @(posedge clk_125m or negedge rst_125m) begin
        if (!rst_125m) begin
          wr_q     <= '0;
          cm_q     <= '0;
          rd_q     <= '0;
          in_pkt_q <= 1'b0;
          half_q   <= 1'b0;
          sop_q    <= 1'b0;
          hi_q     <= '0;
          drop_q   <= 1'b0;
        end else begin
          wr_q     <= wr_d;
          cm_q     <= cm_d;
          rd_q     <= rd_q + PW'(rd_inc);
          in_pkt_q <= in_pkt_d;
          half_q   <= half_d;
          sop_q    <= sop_d;
          hi_q     <= hi_d;
          drop_q   <= drop;
        end
      end

      // Packet buffer storage.
      always_ff @(posedge clk_125m) begin
        if (wr_en) mem[base[FIFO_AW-1:0]] <= word;
      end

      assign rd_word[k]      = mem[rd_q[FIFO_AW-1:0]];
      assign pend[k]         = (cm_q != rd_q);
      assign bus.pkt_drop[k] = drop_q;
    end else begin : g_off
      assign rd_word[k] = '0;
      assign pend[k]    = 1'b0;
    end
  end

  // Round-robin pick of the first pending channel after last_ch.
  always_comb begin
    sel_ch = last_q;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= CH_NUM; i++) begin
      cand = 2'((32'(last_q) + i) % CH_NUM);
      if (!found && pend[cand]) begin
        found  = 1'b1;
        sel_ch = cand;
      end
    end
  end

  // Arbiter next state: a transfer ends on the read of the eop word.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: if (|pend) state_d = StArb;
      StArb: begin
        cur_d   = sel_ch;
        state_d = StXfer;
      end
      StXfer: begin
        if (fire && rd_word[cur_q][16]) begin
          state_d = StIdle;
          last_d  = cur_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state and registered read port.
  always_ff @(posedge clk_125m or negedge rst_125m) begin
    if (!rst_125m) begin
      state_q <= StIdle;
      cur_q   <= '0;
      last_q  <= 2'(CH_NUM - 1);
      dval_q  <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      dval_q  <= fire;
      if (fire) begin
        data_q <= rd_word[cur_q];
        ch_q   <= cur_q;
      end
    end
  end
endmodule
